// File: rtl/mil1553_pkg.sv
// mil1553_pkg
//   Shared definitions for the MIL-STD-1553 Manchester II word generator
//   (and the matching decoder): FSM state encoding, error-injection codes,
//   the 6-half-bit sync patterns and the clocks-per-bit calculation.
package mil1553_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_PARITY,
    ST_GAP
  } state_t;

  // s_err codes
  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_PARITY = 2'b01;
  localparam logic [1:0] ERR_MANCH  = 2'b10;
  localparam logic [1:0] ERR_SYNC   = 2'b11;

  // Sync half-bit levels (tx0, non-inverted), leftmost half-bit sent first
  localparam logic [5:0] SYNC_CMD  = 6'b000111;
  localparam logic [5:0] SYNC_DATA = 6'b111000;

  // Clocks per 1553 bit time
  function automatic int calc_cpb(input int clock_hz, input int bit_hz);
    return clock_hz / bit_hz;
  endfunction

endpackage

// File: rtl/mil1553_word_gen_if.sv
// mil1553_word_gen_if
//   Word-submission handshake into the 1553 word generator.
//   s_data  : 16-bit payload
//   s_cmd   : 1 = command/status sync, 0 = data sync
//   s_err   : error-injection code (see mil1553_pkg)
//   s_valid : word present
//   s_ready : generator can accept
//   master drives a word, slave (the generator) accepts it.
interface mil1553_word_gen_if;
  logic [15:0] s_data;
  logic        s_cmd;
  logic [1:0]  s_err;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_cmd, output s_err, output s_valid, input s_ready);
  modport slave  (input s_data, input s_cmd, input s_err, input s_valid, output s_ready);
endinterface

// File: rtl/mil1553_halfbit_timer.sv
// mil1553_halfbit_timer
//   Prescaler producing a one-cycle strobe every HALF cycles while enabled.
//   aclk   : clock
//   arstn  : asynchronous active-low reset
//   clear  : restart the count (word acceptance)
//   en     : count enable (word being sent)
//   strobe : half-bit boundary; the next half-bit level is taken on this edge
module mil1553_halfbit_timer #(
  parameter int HALF = 25
) (
  input  logic aclk,
  input  logic arstn,
  input  logic clear,
  input  logic en,
  output logic strobe
);

  localparam int CW = $clog2(HALF + 1);

  logic [CW-1:0] cnt;

  // The count runs 1..HALF after the first pass; clearing to 0 makes the
  // first strobe land HALF+1 cycles after clear, which absorbs the one-cycle
  // lag of the registered outputs behind acceptance.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CW'(HALF)) ? CW'(1) : cnt + CW'(1);
    end
  end

  assign strobe = en && (cnt == CW'(HALF));

endmodule

// File: rtl/mil1553_word_gen.sv
// mil1553_word_gen
//   MIL-STD-1553 Manchester II word generator. Accepts 16-bit words over a
//   valid/ready handshake and sends sync (3 bit times), 16 data bits MSB first
//   and odd parity on the differential pair, followed by an idle gap.
//   aclk, arstn        : clock, asynchronous active-low reset
//   s (slave modport)  : s_data, s_cmd, s_err, s_valid in; s_ready out
//   tx0_1553, tx1_1553 : differential transmit pair
//   en_diff            : transmitter enable
//   busy               : from first sync level until s_ready returns
//   done               : one-cycle pulse as the word ends
module mil1553_word_gen
  import mil1553_pkg::*;
#(
  parameter int CLOCK_SPEED = 50_000_000,
  parameter int BIT_RATE    = 1_000_000,
  parameter int GAP_BITS    = 4,
  parameter int INVERT_DATA = 0
) (
  input  logic              aclk,
  input  logic              arstn,
  mil1553_word_gen_if.slave s,
  output logic              tx0_1553,
  output logic              tx1_1553,
  output logic              en_diff,
  output logic              busy,
  output logic              done
);

  localparam int CPB        = calc_cpb(CLOCK_SPEED, BIT_RATE);
  localparam int H          = CPB / 2;
  localparam int GAP_CYCLES = GAP_BITS * CPB;
  localparam int GW         = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam bit INV        = (INVERT_DATA != 0);

  if ((CPB % 2) != 0 || CPB < 4) begin : g_bad_cpb
    $error("mil1553_word_gen: CLOCK_SPEED/BIT_RATE must be even and >= 4");
  end
  if (GAP_BITS < 0 || GAP_BITS > 255) begin : g_bad_gap
    $error("mil1553_word_gen: GAP_BITS must be in 0..255");
  end

  state_t        state, state_nx;
  logic [5:0]    hidx, hidx_nx;
  logic [15:0]   data_q;
  logic          cmd_q;
  logic [1:0]    err_q;
  logic [GW-1:0] gap_cnt;
  logic          ready_q;
  logic          accept, strobe, sending, last_half, active_nx, level_nx;
  logic [5:0]    sync_pat;
  logic [4:0]    rel;
  logic          dbit, par;

  assign accept    = s.s_valid & ready_q;
  assign sending   = (state == ST_SYNC) || (state == ST_DATA) || (state == ST_PARITY);
  assign s.s_ready = ready_q;

  mil1553_halfbit_timer #(.HALF(H)) u_timer (
    .aclk   (aclk),
    .arstn  (arstn),
    .clear  (accept),
    .en     (sending),
    .strobe (strobe)
  );

  // Next state and half-bit index. Half-bits 0-5 are sync, 6-37 data,
  // 38-39 parity; the strobe after half-bit 39 closes the word.
  always_comb begin
    state_nx  = state;
    hidx_nx   = hidx;
    last_half = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_SYNC;
          hidx_nx  = 6'd0;
        end
      end
      ST_SYNC: begin
        if (strobe) begin
          hidx_nx = hidx + 6'd1;
          if (hidx == 6'd5) state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (strobe) begin
          hidx_nx = hidx + 6'd1;
          if (hidx == 6'd37) state_nx = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (strobe) begin
          if (hidx == 6'd39) begin
            last_half = 1'b1;
            hidx_nx   = 6'd0;
            state_nx  = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end else begin
            hidx_nx = hidx + 6'd1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Non-inverted tx0 level for the half-bit that will be on the line after
  // this edge. A data/parity 1 is low then high; the Manchester error repeats
  // the first-half level of data bit 15 in its second half.
  always_comb begin
    sync_pat = ((cmd_q ^ (err_q == ERR_SYNC)) != 1'b0) ? SYNC_CMD : SYNC_DATA;
    rel      = 5'(hidx_nx - 6'd6);
    dbit     = data_q[4'd15 - rel[4:1]];
    par      = ~(^data_q) ^ (err_q == ERR_PARITY);
    level_nx = 1'b0;
    if (hidx_nx < 6'd6) begin
      level_nx = sync_pat[3'd5 - hidx_nx[2:0]];
    end else if (hidx_nx < 6'd38) begin
      if (!rel[0] || (err_q == ERR_MANCH && rel[4:1] == 4'd0)) level_nx = ~dbit;
      else level_nx = dbit;
    end else begin
      level_nx = hidx_nx[0] ? par : ~par;
    end
  end

  // The line is driven only after the acceptance cycle, so outputs trail
  // the state by one edge.
  assign active_nx = (state != ST_IDLE) &&
                     ((state_nx == ST_SYNC) || (state_nx == ST_DATA) || (state_nx == ST_PARITY));

  // State, index, latched word fields and gap countdown
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state   <= ST_IDLE;
      hidx    <= 6'd0;
      data_q  <= 16'd0;
      cmd_q   <= 1'b0;
      err_q   <= ERR_NONE;
      gap_cnt <= '0;
    end else begin
      state <= state_nx;
      hidx  <= hidx_nx;
      if (accept) begin
        data_q <= s.s_data;
        cmd_q  <= s.s_cmd;
        err_q  <= s.s_err;
      end
      if (state_nx == ST_GAP && state != ST_GAP) gap_cnt <= GW'(GAP_CYCLES - 1);
      else if (state == ST_GAP) gap_cnt <= gap_cnt - GW'(1);
    end
  end

  // Registered outputs; s_ready stays low for the first edge after reset
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      ready_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      en_diff  <= 1'b0;
      tx0_1553 <= 1'b0;
      tx1_1553 <= 1'b0;
    end else begin
      ready_q  <= (state_nx == ST_IDLE);
      busy     <= (state != ST_IDLE) && (state_nx != ST_IDLE);
      done     <= last_half;
      en_diff  <= active_nx;
      tx0_1553 <= active_nx ? (level_nx ^ INV) : 1'b0;
      tx1_1553 <= active_nx ? ~(level_nx ^ INV) : 1'b0;
    end
  end

endmodule

// File: tb/tb_mil1553_word_gen.sv
// tb_mil1553_word_gen
//   Self-checking bench for mil1553_word_gen. DUT a uses the default build
//   (C = 50, H = 25, GAP_BITS = 4); DUT b is built with INVERT_DATA = 1,
//   BIT_RATE = 500_000, GAP_BITS = 0 (C = 100, H = 50). Expected half-bit
//   patterns are queued as words are driven and popped as words come back.
module tb_mil1553_word_gen;

  logic aclk = 1'b0;
  logic arstn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic tx0_a, tx1_a, en_a, busy_a, done_a;
  logic tx0_b, tx1_b, en_b, busy_b, done_b;
  logic mon_sel = 1'b0;
  logic m_tx0, m_tx1, m_en, m_ready;

  logic [39:0] exp_q[$];

  mil1553_word_gen_if if_a ();
  mil1553_word_gen_if if_b ();

  mil1553_word_gen dut_a (
    .aclk(aclk), .arstn(arstn), .s(if_a),
    .tx0_1553(tx0_a), .tx1_1553(tx1_a), .en_diff(en_a), .busy(busy_a), .done(done_a)
  );

  mil1553_word_gen #(
    .CLOCK_SPEED(50_000_000), .BIT_RATE(500_000), .GAP_BITS(0), .INVERT_DATA(1)
  ) dut_b (
    .aclk(aclk), .arstn(arstn), .s(if_b),
    .tx0_1553(tx0_b), .tx1_1553(tx1_b), .en_diff(en_b), .busy(busy_b), .done(done_b)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  assign m_tx0   = mon_sel ? tx0_b : tx0_a;
  assign m_tx1   = mon_sel ? tx1_b : tx1_a;
  assign m_en    = mon_sel ? en_b : en_a;
  assign m_ready = mon_sel ? if_b.s_ready : if_a.s_ready;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference tx0 half-bit levels of one word, leftmost half-bit first
  function automatic logic [39:0] encode(input logic [15:0] d, input logic cmd,
                                         input logic [1:0] err, input bit inv);
    logic [39:0] r;
    logic sc, p, b;
    sc = cmd ^ (err == 2'b11);
    r[39:34] = sc ? 6'b000111 : 6'b111000;
    for (int i = 0; i < 16; i++) begin
      b = d[15 - i];
      r[33 - 2*i] = ~b;
      r[32 - 2*i] = (err == 2'b10 && i == 0) ? ~b : b;
    end
    p = ~(^d) ^ (err == 2'b01);
    r[1] = ~p;
    r[0] = p;
    if (inv) r = ~r;
    return r;
  endfunction

  task automatic drive(input bit sel, input logic [15:0] d, input logic cmd,
                       input logic [1:0] err, input logic valid);
    if (sel) begin
      if_b.s_data = d; if_b.s_cmd = cmd; if_b.s_err = err; if_b.s_valid = valid;
    end else begin
      if_a.s_data = d; if_a.s_cmd = cmd; if_a.s_err = err; if_a.s_valid = valid;
    end
  endtask

  // Waits for s_ready, offers one word and returns the acceptance edge count.
  // Without hold, valid drops and the fields are scrambled after acceptance.
  task automatic send(input bit sel, input logic [15:0] d, input logic cmd,
                      input logic [1:0] err, input bit hold, output int a, output bit ok);
    mon_sel = sel;
    ok = 1'b0;
    a  = 0;
    for (int t = 0; t < 5000; t++) begin
      if (m_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge aclk);
    end
    if (!ok) return;
    drive(sel, d, cmd, err, 1'b1);
    @(negedge aclk);
    a = cyc;
    if (!hold) drive(sel, ~d, ~cmd, ~err, 1'b0);
  endtask

  // Records one word from the line: one level per half-bit, counting any
  // level change inside a half-bit, en_diff drop or broken tx1 = ~tx0.
  task automatic capture(input bit sel, input int h, output logic [39:0] halves,
                         output int start, output int stop, output int glitches,
                         output bit tail_idle, output bit tail_done, output bit seen);
    mon_sel = sel;
    halves = '0; start = 0; stop = 0; glitches = 0;
    tail_idle = 1'b0; tail_done = 1'b0; seen = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge aclk);
      if (m_en === 1'b1) begin seen = 1'b1; break; end
    end
    if (!seen) return;
    start = cyc;
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < h; j++) begin
        if (k != 0 || j != 0) @(negedge aclk);
        if (j == 0) halves[39 - k] = m_tx0;
        else if (m_tx0 !== halves[39 - k]) glitches++;
        if (m_en !== 1'b1 || m_tx1 !== ~m_tx0) glitches++;
      end
    end
    @(negedge aclk);
    stop      = cyc;
    tail_idle = (m_en === 1'b0) && (m_tx0 === 1'b0) && (m_tx1 === 1'b0);
    tail_done = sel ? done_b : done_a;
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 2'b00, 1'b0);
    drive(1'b1, 16'h0, 1'b0, 2'b00, 1'b0);
    repeat (3) @(negedge aclk);
    checks++; if ({tx0_a, tx1_a, en_a, busy_a, done_a} !== 5'b0) begin errors++;
      $display("[TB] FAIL reset_outputs_a: got %b expected 00000", {tx0_a, tx1_a, en_a, busy_a, done_a}); end
    checks++; if ({tx0_b, tx1_b, en_b, busy_b, done_b} !== 5'b0) begin errors++;
      $display("[TB] FAIL reset_outputs_b: got %b expected 00000", {tx0_b, tx1_b, en_b, busy_b, done_b}); end
    checks++; if (if_a.s_ready !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_ready: got %b expected 0", if_a.s_ready); end
    #2 arstn = 1'b1;
    #1;
    checks++; if (if_a.s_ready !== 1'b0) begin errors++;
      $display("[TB] FAIL ready_before_edge: got %b expected 0", if_a.s_ready); end
    @(negedge aclk);
    checks++; if ({if_a.s_ready, if_b.s_ready} !== 2'b11) begin errors++;
      $display("[TB] FAIL ready_after_edge: got %b expected 11", {if_a.s_ready, if_b.s_ready}); end
  endtask

  task automatic test_cmd_zero();
    int a, st, sp, g, rdy;
    bit ok, ti, td, seen, got;
    logic [39:0] obs, exp0, x;
    exp0 = {6'b000111, {16{2'b10}}, 2'b01};
    exp_q.push_back(exp0);
    send(1'b0, 16'h0000, 1'b1, 2'b00, 1'b0, a, ok);
    checks++; if (busy_a !== 1'b0) begin errors++;
      $display("[TB] FAIL busy_at_accept: got %b expected 0", busy_a); end
    capture(1'b0, 25, obs, st, sp, g, ti, td, seen);
    x = exp_q.pop_front();
    checks++; if (!(ok && seen)) begin errors++;
      $display("[TB] FAIL cmd0_word_seen: got %b expected 1", ok && seen); end
    checks++; if (obs !== x) begin errors++;
      $display("[TB] FAIL cmd0_halves: got %h expected %h", obs, x); end
    checks++; if (g !== 0) begin errors++;
      $display("[TB] FAIL cmd0_glitches: got %0d expected 0", g); end
    checks++; if (st !== a + 1) begin errors++;
      $display("[TB] FAIL cmd0_first_level: got %0d expected %0d", st, a + 1); end
    checks++; if (sp !== a + 1001 || !ti || !td) begin errors++;
      $display("[TB] FAIL cmd0_done: got edge %0d idle %b done %b expected edge %0d idle 1 done 1", sp, ti, td, a + 1001); end
    checks++; if (busy_a !== 1'b1) begin errors++;
      $display("[TB] FAIL busy_in_gap: got %b expected 1", busy_a); end
    @(negedge aclk);
    checks++; if (done_a !== 1'b0) begin errors++;
      $display("[TB] FAIL done_one_cycle: got %b expected 0", done_a); end
    got = 1'b0; rdy = 0;
    for (int t = 0; t < 2000; t++) begin
      if (if_a.s_ready === 1'b1) begin got = 1'b1; rdy = cyc; break; end
      @(negedge aclk);
    end
    checks++; if (!got || rdy !== a + 1201) begin errors++;
      $display("[TB] FAIL cmd0_ready_edge: got %0d expected %0d", rdy, a + 1201); end
    checks++; if (busy_a !== 1'b0) begin errors++;
      $display("[TB] FAIL busy_after_gap: got %b expected 0", busy_a); end
  endtask

  task automatic test_data_sync();
    int a, st, sp, g;
    bit ok, ti, td, seen;
    logic [39:0] obs, x;
    exp_q.push_back(encode(16'h0001, 1'b0, 2'b00, 1'b0));
    send(1'b0, 16'h0001, 1'b0, 2'b00, 1'b0, a, ok);
    capture(1'b0, 25, obs, st, sp, g, ti, td, seen);
    x = exp_q.pop_front();
    checks++; if (!(ok && seen) || obs !== x) begin errors++;
      $display("[TB] FAIL data1_halves: got %h expected %h", obs, x); end
    checks++; if (obs[39:34] !== 6'b111000 || obs[3:0] !== 4'b0110) begin errors++;
      $display("[TB] FAIL data1_sync_bit0_parity: got %b %b expected 111000 0110", obs[39:34], obs[3:0]); end
    checks++; if (g !== 0) begin errors++;
      $display("[TB] FAIL data1_pair: got %0d bad cycles expected 0", g); end
  endtask

  // Two words with s_valid held; idle cycles counted between them
  task automatic test_back_to_back(input bit sel, input int h, input logic [15:0] d1,
                                   input logic [15:0] d2, input int exp_idle, input bit inv);
    int a, s1, e1, s2, e2, g1, g2;
    bit ok, seen1, seen2, ti, td, got;
    logic [39:0] o1, o2, x;
    exp_q.push_back(encode(d1, 1'b1, 2'b00, inv));
    exp_q.push_back(encode(d2, 1'b1, 2'b00, inv));
    send(sel, d1, 1'b1, 2'b00, 1'b1, a, ok);
    drive(sel, d2, 1'b1, 2'b00, 1'b1);
    capture(sel, h, o1, s1, e1, g1, ti, td, seen1);
    got = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      if (m_ready === 1'b1) begin got = 1'b1; break; end
      @(negedge aclk);
    end
    @(negedge aclk);
    drive(sel, 16'h5A5A, 1'b0, 2'b00, 1'b0);
    capture(sel, h, o2, s2, e2, g2, ti, td, seen2);
    checks++; if (!(ok && got && seen1 && seen2)) begin errors++;
      $display("[TB] FAIL b2b_words_seen dut %0d: got %b%b%b%b expected 1111", sel, ok, got, seen1, seen2); end
    x = exp_q.pop_front();
    checks++; if (o1 !== x) begin errors++;
      $display("[TB] FAIL b2b_word1 dut %0d: got %h expected %h", sel, o1, x); end
    x = exp_q.pop_front();
    checks++; if (o2 !== x) begin errors++;
      $display("[TB] FAIL b2b_word2 dut %0d: got %h expected %h", sel, o2, x); end
    checks++; if (g1 + g2 !== 0) begin errors++;
      $display("[TB] FAIL b2b_glitches dut %0d: got %0d expected 0", sel, g1 + g2); end
    checks++; if (e1 - s1 !== 40 * h || s1 !== a + 1) begin errors++;
      $display("[TB] FAIL b2b_length dut %0d: got %0d from %0d expected %0d from %0d", sel, e1 - s1, s1, 40 * h, a + 1); end
    checks++; if (s2 - e1 !== exp_idle) begin errors++;
      $display("[TB] FAIL b2b_idle dut %0d: got %0d expected %0d", sel, s2 - e1, exp_idle); end
  endtask

  task automatic test_errors();
    int a, st, sp, g;
    bit ok, ti, td, seen;
    logic [39:0] obs, x;
    logic [5:0] want;
    for (int e = 1; e <= 3; e++) begin
      exp_q.push_back(encode(16'hA5A5, 1'b1, 2'(e), 1'b0));
      send(1'b0, 16'hA5A5, 1'b1, 2'(e), 1'b0, a, ok);
      capture(1'b0, 25, obs, st, sp, g, ti, td, seen);
      x = exp_q.pop_front();
      checks++; if (!(ok && seen) || obs !== x || g !== 0) begin errors++;
        $display("[TB] FAIL err%0d_word: got %h glitches %0d expected %h glitches 0", e, obs, g, x); end
      case (e)
        1: begin want = 6'b000010; checks++; if ({4'b0, obs[1:0]} !== want) begin errors++;
             $display("[TB] FAIL err1_parity: got %b expected 10", obs[1:0]); end end
        2: begin want = 6'b000000; checks++; if ({4'b0, obs[33:32]} !== want) begin errors++;
             $display("[TB] FAIL err2_bit15: got %b expected 00", obs[33:32]); end end
        default: begin want = 6'b111000; checks++; if (obs[39:34] !== want) begin errors++;
             $display("[TB] FAIL err3_sync: got %b expected 111000", obs[39:34]); end end
      endcase
    end
  endtask

  task automatic test_async_reset();
    int a, st, sp, g;
    bit ok, ti, td, seen;
    logic [39:0] obs, x;
    send(1'b0, 16'h1234, 1'b1, 2'b00, 1'b0, a, ok);
    repeat (400) @(negedge aclk);
    checks++; if (!ok || en_a !== 1'b1) begin errors++;
      $display("[TB] FAIL midword_active: got %b expected 1", en_a); end
    #2 arstn = 1'b0;
    #1;
    checks++; if ({tx0_a, tx1_a, en_a, busy_a, done_a, if_a.s_ready} !== 6'b0) begin errors++;
      $display("[TB] FAIL async_reset_idle: got %b expected 000000", {tx0_a, tx1_a, en_a, busy_a, done_a, if_a.s_ready}); end
    #1 arstn = 1'b1;
    @(negedge aclk);
    checks++; if (if_a.s_ready !== 1'b1 || en_a !== 1'b0) begin errors++;
      $display("[TB] FAIL post_reset_ready: got ready %b en %b expected 1 0", if_a.s_ready, en_a); end
    exp_q.push_back(encode(16'h0F0F, 1'b0, 2'b00, 1'b0));
    send(1'b0, 16'h0F0F, 1'b0, 2'b00, 1'b0, a, ok);
    capture(1'b0, 25, obs, st, sp, g, ti, td, seen);
    x = exp_q.pop_front();
    checks++; if (!(ok && seen) || obs !== x || g !== 0 || st !== a + 1) begin errors++;
      $display("[TB] FAIL post_reset_word: got %h start %0d expected %h start %0d", obs, st, x, a + 1); end
  endtask

  initial begin
    test_reset();
    test_cmd_zero();
    test_data_sync();
    test_back_to_back(1'b0, 25, 16'hFFFF, 16'h8000, 202, 1'b0);
    test_errors();
    test_async_reset();
    test_back_to_back(1'b1, 50, 16'h1234, 16'h00FF, 2, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
